// File: rtl/cordic_phase_gen_pkg.sv
// Shared types and constants for the CORDIC phase generator and its helpers.
package cordic_phase_gen_pkg;

    localparam int unsigned PHASE_WIDTH_C         = 32;
    localparam int          CORDIC_GAIN_INV_16B_C = 19897;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPend
    } state_e;

endpackage

// File: rtl/cordic_valid_delay.sv
// Single-bit valid delay line; out is the input delayed by DEPTH_P cycles.
module cordic_valid_delay #(
    parameter int unsigned DEPTH_P = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    output logic valid_dly
);

    logic [DEPTH_P-1:0] shift_q;

    generate
        if (DEPTH_P == 1) begin : g_single
            // One-stage delay.
            always_ff @(posedge clk) begin
                if (rst) shift_q <= '0;
                else     shift_q <= valid;
            end
        end else begin : g_multi
            // Shift valid tags toward the MSB, which is the output tap.
            always_ff @(posedge clk) begin
                if (rst) shift_q <= '0;
                else     shift_q <= {shift_q[DEPTH_P-2:0], valid};
            end
        end
    endgenerate

    assign valid_dly = shift_q[DEPTH_P-1];

endmodule

// File: rtl/cordic_phase_gen.sv
// NCO angle feeder for the CORDIC rotator, with phase-continuous config updates
// and a valid tag aligned to the CORDIC output.
module cordic_phase_gen
    import cordic_phase_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P   = 16,
    parameter int unsigned NR_OF_STAGES_P = 16,
    parameter int          GAIN_INV_P     = CORDIC_GAIN_INV_16B_C
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PHASE_WIDTH_C-1:0] cfg_fcw,
    input  logic [PHASE_WIDTH_C-1:0] cfg_offset,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic                     smp_en,
    input  logic                     phase_clr,
    output logic [PHASE_WIDTH_C-1:0] egr_angle_vector,
    output logic [DATA_WIDTH_P-1:0]  egr_x_vector,
    output logic [DATA_WIDTH_P-1:0]  egr_y_vector,
    output logic                     egr_valid,
    output logic                     egr_phase_wrap,
    output logic                     aligned_valid
);

    state_e                   state_q;
    logic [PHASE_WIDTH_C-1:0] acc_q, fcw_q, offset_q;
    logic [PHASE_WIDTH_C-1:0] shadow_fcw_q, shadow_offset_q;
    logic [PHASE_WIDTH_C-1:0] fcw_used, acc_base;
    logic [PHASE_WIDTH_C:0]   step_sum;
    logic                     sampling;

    assign cfg_ready = (state_q != StPend);

    // Phase step for this cycle: a pending update applies its increment on the
    // sample that retires it; phase_clr restarts the step from zero.
    always_comb begin
        fcw_used = (state_q == StPend) ? shadow_fcw_q : fcw_q;
        acc_base = phase_clr ? '0 : acc_q;
        step_sum = {1'b0, acc_base} + {1'b0, fcw_used};
        sampling = smp_en && (state_q != StIdle);
    end

    // Control FSM, accumulator and registered egress outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            acc_q            <= '0;
            fcw_q            <= '0;
            offset_q         <= '0;
            shadow_fcw_q     <= '0;
            shadow_offset_q  <= '0;
            egr_angle_vector <= '0;
            egr_x_vector     <= '0;
            egr_y_vector     <= '0;
            egr_valid        <= 1'b0;
            egr_phase_wrap   <= 1'b0;
        end else begin
            egr_valid <= sampling;
            if (sampling) begin
                egr_angle_vector <= acc_base + offset_q;
                egr_x_vector     <= DATA_WIDTH_P'(GAIN_INV_P);
                egr_y_vector     <= '0;
                egr_phase_wrap   <= step_sum[PHASE_WIDTH_C];
                acc_q            <= step_sum[PHASE_WIDTH_C-1:0];
            end else if (phase_clr && state_q != StIdle) begin
                acc_q <= '0;
            end

            unique case (state_q)
                StIdle: begin
                    if (cfg_valid) begin
                        fcw_q    <= cfg_fcw;
                        offset_q <= cfg_offset;
                        acc_q    <= '0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    if (cfg_valid) begin
                        shadow_fcw_q    <= cfg_fcw;
                        shadow_offset_q <= cfg_offset;
                        state_q         <= StPend;
                    end
                end
                StPend: begin
                    // The offset switches only after this sample used the old one.
                    if (smp_en) begin
                        fcw_q    <= shadow_fcw_q;
                        offset_q <= shadow_offset_q;
                        state_q  <= StRun;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    cordic_valid_delay #(
        .DEPTH_P (NR_OF_STAGES_P)
    ) u_valid_delay (
        .clk       (clk),
        .rst       (rst),
        .valid     (egr_valid),
        .valid_dly (aligned_valid)
    );

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench for cordic_phase_gen: directed scenarios plus a random run,
// all compared against a sample-level reference model.
module tb_cordic_phase_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cfg_fcw = '0, cfg_offset = '0;
    logic        cfg_valid = 1'b0, smp_en = 1'b0, phase_clr = 1'b0;
    logic        cfg_ready;
    logic [31:0] egr_angle_vector;
    logic [15:0] egr_x_vector, egr_y_vector;
    logic        egr_valid, egr_phase_wrap, aligned_valid;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cordic_phase_gen dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_fcw          (cfg_fcw),
        .cfg_offset       (cfg_offset),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .smp_en           (smp_en),
        .phase_clr        (phase_clr),
        .egr_angle_vector (egr_angle_vector),
        .egr_x_vector     (egr_x_vector),
        .egr_y_vector     (egr_y_vector),
        .egr_valid        (egr_valid),
        .egr_phase_wrap   (egr_phase_wrap),
        .aligned_valid    (aligned_valid)
    );

    // Reference model: configured / pending flags, phase, live and queued config.
    bit          m_run, m_pend;
    logic [31:0] m_acc, m_fcw, m_off, m_sh_fcw, m_sh_off;
    logic [31:0] e_angle;
    logic [15:0] e_x, e_y;
    logic        e_valid, e_wrap;
    bit          vhist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pend = 0;
        m_acc = '0; m_fcw = '0; m_off = '0; m_sh_fcw = '0; m_sh_off = '0;
        e_angle = '0; e_x = '0; e_y = '0; e_valid = 0; e_wrap = 0;
        vhist.delete();
    endtask

    task automatic model_cycle(input bit v, input logic [31:0] f, input logic [31:0] o,
                               input bit s, input bit c);
        bit          hs;
        logic [31:0] inc, base;
        logic [32:0] sum;
        hs      = v && !m_pend;
        e_valid = 0;
        if (!m_run) begin
            if (hs) begin
                m_fcw = f; m_off = o; m_acc = '0; m_run = 1;
            end
        end else begin
            inc  = m_pend ? m_sh_fcw : m_fcw;
            base = c ? 32'h0 : m_acc;
            if (s) begin
                sum     = {1'b0, base} + {1'b0, inc};
                e_angle = base + m_off;
                e_wrap  = sum[32];
                e_x     = 16'd19897;
                e_y     = '0;
                e_valid = 1;
                m_acc   = sum[31:0];
                if (m_pend) begin
                    m_fcw = m_sh_fcw; m_off = m_sh_off; m_pend = 0;
                end
            end else if (c) begin
                m_acc = '0;
            end
            if (hs) begin
                m_sh_fcw = f; m_sh_off = o; m_pend = 1;
            end
        end
    endtask

    // One clock with the given inputs; checks cfg_ready before and all outputs after.
    task automatic step(input bit v, input logic [31:0] f, input logic [31:0] o,
                        input bit s, input bit c, input bit r);
        bit exp_al;
        rst = r; cfg_valid = v; cfg_fcw = f; cfg_offset = o; smp_en = s; phase_clr = c;
        if (!r) chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, !m_pend});
        @(posedge clk);
        if (r) model_reset();
        else   model_cycle(v, f, o, s, c);
        vhist.push_back(e_valid);
        exp_al = (vhist.size() > 16) ? vhist[vhist.size() - 17] : 1'b0;
        #1;
        chk("egr_valid", {31'b0, egr_valid}, {31'b0, e_valid});
        chk("aligned_valid", {31'b0, aligned_valid}, {31'b0, exp_al});
        chk("egr_angle", egr_angle_vector, e_angle);
        chk("egr_wrap", {31'b0, egr_phase_wrap}, {31'b0, e_wrap});
        chk("egr_x", {16'b0, egr_x_vector}, {16'b0, e_x});
        chk("egr_y", {16'b0, egr_y_vector}, {16'b0, e_y});
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic samples(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        logic [31:0] quad [5];
        bit          pat  [5];
        quad[0] = 32'h0; quad[1] = 32'h4000_0000; quad[2] = 32'h8000_0000;
        quad[3] = 32'hC000_0000; quad[4] = 32'h0;
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0;
        model_reset();

        // Quarter-turn stepping with wrap on the 4th sample.
        do_reset();
        step(1, 32'h4000_0000, 32'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0, 0);
            chk("quad_angle", egr_angle_vector, quad[i]);
            chk("quad_wrap", {31'b0, egr_phase_wrap}, {31'b0, i == 3});
            chk("quad_x", {16'b0, egr_x_vector}, 32'd19897);
        end
        // Gapped strobes, then drain so every tag reaches aligned_valid.
        for (int i = 0; i < 5; i++) step(0, 0, 0, pat[i], 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);

        // Mid-stream retune: old phase/offset on the next sample, new after.
        do_reset();
        step(1, 32'h1000_0000, 32'h0, 0, 0, 0);
        samples(3);
        step(1, 32'h2000_0000, 32'h4000_0000, 0, 0, 0);
        chk("pend_ready", {31'b0, cfg_ready}, 32'd0);
        step(1, 32'hDEAD_BEEF, 32'h1234_5678, 1, 0, 0);
        chk("retune_old", egr_angle_vector, 32'h3000_0000);
        chk("retune_ready", {31'b0, cfg_ready}, 32'd1);
        step(0, 0, 0, 1, 0, 0);
        chk("retune_new0", egr_angle_vector, 32'h9000_0000);
        step(0, 0, 0, 1, 0, 0);
        chk("retune_new1", egr_angle_vector, 32'hB000_0000);

        // phase_clr with a strobe.
        do_reset();
        step(1, 32'h1000_0000, 32'h100, 0, 0, 0);
        samples(3);
        step(0, 0, 0, 1, 1, 0);
        chk("clr_angle", egr_angle_vector, 32'h0000_0100);
        chk("clr_wrap", {31'b0, egr_phase_wrap}, 32'd0);
        step(0, 0, 0, 1, 0, 0);
        chk("clr_next", egr_angle_vector, 32'h1000_0100);

        // Strobes while unconfigured are ignored.
        do_reset();
        samples(3);
        step(1, 32'h7, 32'h55, 1, 1, 0);
        chk("idle_valid", {31'b0, egr_valid}, 32'd0);
        step(0, 0, 0, 1, 0, 0);
        chk("idle_first", egr_angle_vector, 32'h55);

        // Reset with tags in flight, then restart streaming immediately.
        samples(5);
        do_reset();
        chk("rst_angle", egr_angle_vector, 32'h0);
        step(1, 32'h0123_4567, 32'h89AB_CDEF, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 7) == 0, $urandom, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 149) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
